// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the write-back arbiter.
package wb_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  // One-hot register mask; x0 is never reported as busy.
  function automatic logic [NREGS-1:0] onehot_reg(input logic [REG_AW-1:0] addr);
    logic [NREGS-1:0] m;
    m       = '0;
    m[addr] = 1'b1;
    m[0]    = 1'b0;
    return m;
  endfunction
endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the result sources / regfile / hazard unit and the arbiter.
interface wb_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                     a_valid;
  logic                     a_ready;
  logic [wb_pkg::REG_AW-1:0] a_addr;
  logic [wb_pkg::XLEN-1:0]  a_data;
  logic                     b_valid;
  logic                     b_ready;
  logic [wb_pkg::REG_AW-1:0] b_addr;
  logic [wb_pkg::XLEN-1:0]  b_data;
  logic                     we;
  logic [wb_pkg::REG_AW-1:0] wa;
  logic [wb_pkg::XLEN-1:0]  wd;
  logic [wb_pkg::NREGS-1:0] busy_mask;
  logic [CW-1:0]            fifo_count;

  // Pipeline side: produces results, consumes handshakes and regfile write.
  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, we, wa, wd, busy_mask, fifo_count
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, we, wa, wd, busy_mask, fifo_count
  );
endinterface

// File: rtl/wb_arbiter_fifo.sv
// Source-B result FIFO; exposes every slot plus per-slot valid so the
// arbiter can build the pending-write mask.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  wb_req_t                 push_req,
  input  logic                    pop,
  output wb_req_t                 head,
  output wb_req_t [DEPTH-1:0]     entries,
  output logic    [DEPTH-1:0]     entry_vld,
  output logic    [CW-1:0]        count
);
  wb_req_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = push_req;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer/count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; slot validity is derived from the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Slot i is live when its distance from the read pointer is below the count.
  always_comb begin : vld_gen
    logic [PW-1:0] off;
    entry_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = PW'(i) - rd_q;
      entry_vld[i] = {1'b0, off} < cnt_q;
    end
  end

  assign head    = mem_q[rd_q];
  assign entries = mem_q;
  assign count   = cnt_q;
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: sole driver of the regfile write port. Source A (ALU)
// has priority; source B (LSU/muldiv) is buffered and forced through after
// STARVE_LIMIT consecutive A grants. Optional perf counters: WB_PERF_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_arbiter_if.slave bus
`ifdef WB_PERF_EN
  ,
  output logic [31:0] perf_a_stall,
  output logic [31:0] perf_b_force
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_req_t              head;
  wb_req_t [DEPTH-1:0]  entries;
  logic    [DEPTH-1:0]  entry_vld;
  logic    [CW-1:0]     count;
  logic                 empty, push, pop, force_b, grant_a, grant_b;
  wb_req_t              sel;

  logic [SW-1:0]     starve_q, starve_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] wa_q, wa_d;
  logic [XLEN-1:0]   wd_q, wd_d;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_req  ('{addr: bus.b_addr, data: bus.b_data}),
    .pop       (pop),
    .head      (head),
    .entries   (entries),
    .entry_vld (entry_vld),
    .count     (count)
  );

  // Accept and grant decision; b_ready uses the pre-pop count on purpose.
  always_comb begin
    empty       = (count == '0);
    bus.b_ready = (count < CW'(DEPTH));
    push        = bus.b_valid & bus.b_ready & (bus.b_addr != '0);
    force_b     = (starve_q == SW'(STARVE_LIMIT)) & ~empty;
    bus.a_ready = ~force_b;
    grant_a     = ~force_b & bus.a_valid;
    grant_b     = ~empty & (force_b | ~bus.a_valid);
    pop         = grant_b;
    sel         = grant_a ? '{addr: bus.a_addr, data: bus.a_data} : head;
  end

  // Starvation counter: counts A wins over a waiting B, saturating.
  always_comb begin
    starve_d = starve_q;
    if (grant_b || empty)
      starve_d = '0;
    else if (grant_a && starve_q != SW'(STARVE_LIMIT))
      starve_d = starve_q + 1'b1;
  end

  // Output stage next-state; x0 writes retire silently.
  always_comb begin
    we_d = 1'b0;
    wa_d = wa_q;
    wd_d = wd_q;
    if (grant_a || grant_b) begin
      we_d = (sel.addr != '0);
      wa_d = sel.addr;
      wd_d = sel.data;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= '0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      starve_q <= starve_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
    end
  end

  // Pending-write mask from registered state only.
  always_comb begin
    bus.busy_mask = we_q ? onehot_reg(wa_q) : '0;
    for (int i = 0; i < DEPTH; i++)
      if (entry_vld[i]) bus.busy_mask = bus.busy_mask | onehot_reg(entries[i].addr);
  end

  assign bus.we         = we_q;
  assign bus.wa         = wa_q;
  assign bus.wd         = wd_q;
  assign bus.fifo_count = count;

`ifdef WB_PERF_EN
  logic [31:0] stall_q, stall_d, forced_q, forced_d;

  // Free-running wrapping event counters.
  always_comb begin
    stall_d  = stall_q + {31'd0, bus.a_valid & ~bus.a_ready};
    forced_d = forced_q + {31'd0, force_b};
  end

  // Perf counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q  <= '0;
      forced_q <= '0;
    end else begin
      stall_q  <= stall_d;
      forced_q <= forced_d;
    end
  end

  assign perf_a_stall = stall_q;
  assign perf_b_force = forced_q;
`endif
endmodule
